// File: rtl/reg_to_wire_stage_pkg.sv
`default_nettype none
// reg_to_wire_stage_pkg: shared state encoding and default width for datapath output stages.
// Rev 1.0
package reg_to_wire_stage_pkg;

   localparam int DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_t;

endpackage
`default_nettype wire

// File: rtl/stage_data_reg.sv
`default_nettype none
// stage_data_reg: WIDTH-bit negedge register with load enable and async active-low clear.
// Rev 1.0
module stage_data_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_to_wire_stage.sv
`default_nettype none
// reg_to_wire_stage: 2-entry skid buffer presenting registered words on a valid/ready output bus.
// Rev 1.0
module reg_to_wire_stage
   import reg_to_wire_stage_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] xfer_count
);

   stage_state_t     state;
   stage_state_t     state_nxt;
   logic             in_fire;
   logic             out_fire;
   logic             main_load;
   logic             main_from_skid;
   logic             skid_load;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] skid_q;

   // Handshake outputs come straight from the state flops, so no combinational ready path.
   assign out_valid = (state != ST_EMPTY);
   assign in_ready  = (state != ST_TWO);
   assign occupancy = state;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign main_d   = main_from_skid ? skid_q : in_data;

   always_ff @(negedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_nxt = ST_ONE;
                  main_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  state_nxt = ST_TWO;
                  skid_load = 1'b1;
               end else if (out_fire) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  state_nxt      = ST_ONE;
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // A transfer seen by the consumer counts even when a flush lands on the same edge.
   always_ff @(negedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         xfer_count <= '0;
      end else if (out_fire) begin
         xfer_count <= xfer_count + CNT_W'(1);
      end
   end

   stage_data_reg #(
      .WIDTH (WIDTH)
   ) u_main_reg (
      .clk   (CLK),
      .rst_n (RSTn),
      .load  (main_load),
      .d     (main_d),
      .q     (out_data)
   );

   stage_data_reg #(
      .WIDTH (WIDTH)
   ) u_skid_reg (
      .clk   (CLK),
      .rst_n (RSTn),
      .load  (skid_load),
      .d     (in_data),
      .q     (skid_q)
   );

endmodule
`default_nettype wire

// File: tb/tb_reg_to_wire_stage.sv
`default_nettype none
// tb_reg_to_wire_stage: directed and random stimulus against a queue-based model of the stage.
// Rev 1.0
module tb_reg_to_wire_stage;

   logic        CLK;
   logic        RSTn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] xfer_count;

   int          tests;
   int          fails;
   logic [31:0] mq[$];
   logic [31:0] shown;
   logic [15:0] mcnt;
   bit          dead_seen;

   reg_to_wire_stage #(
      .WIDTH (32),
      .CNT_W (16)
   ) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .occupancy  (occupancy),
      .xfer_count (xfer_count)
   );

   initial begin
      CLK = 1'b1;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      chk("in_ready",  {31'd0, in_ready},  {31'd0, mq.size() < 2});
      chk("occupancy", {30'd0, occupancy}, 32'(mq.size()));
      chk("out_data",  out_data, shown);
      chk("xfer_count", {16'd0, xfer_count}, {16'd0, mcnt});
   endtask

   // One active edge: the model works on whole words in a FIFO of depth two.
   task automatic step(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
      bit acc;
      bit dep;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      acc = iv && (mq.size() < 2);
      dep = ordy && (mq.size() > 0);
      @(negedge CLK);
      #1;
      if (dep) begin
         void'(mq.pop_front());
         mcnt = mcnt + 16'd1;
      end
      if (fl) mq.delete();
      else if (acc) mq.push_back(id);
      if (mq.size() > 0) shown = mq[0];
      check_model();
      if (out_valid && out_data == 32'hDEAD0000) dead_seen = 1'b1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      mcnt  = '0;
      shown = '0;
      dead_seen = 1'b0;
      RSTn = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      flush = 1'b0;
      repeat (2) @(negedge CLK);
      #3 RSTn = 1'b1;
      #1 check_model();

      // Single pass
      step(1'b1, 32'h12345678, 1'b1, 1'b0);
      chk("single_valid", {31'd0, out_valid}, 32'd1);
      chk("single_data", out_data, 32'h12345678);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("single_done", {15'd0, out_valid, xfer_count}, {15'd0, 1'b0, 16'd1});

      // Back-pressure fill, third word refused
      step(1'b1, 32'hAAAA0001, 1'b0, 1'b0);
      step(1'b1, 32'hAAAA0002, 1'b0, 1'b0);
      chk("bp_full", {29'd0, in_ready, occupancy}, {29'd0, 1'b0, 2'd2});
      chk("bp_head", out_data, 32'hAAAA0001);
      step(1'b1, 32'hAAAA0003, 1'b0, 1'b0);
      step(1'b1, 32'hAAAA0003, 1'b1, 1'b0);
      chk("bp_out2", out_data, 32'hAAAA0002);
      step(1'b1, 32'hAAAA0003, 1'b1, 1'b0);
      chk("bp_out3", out_data, 32'hAAAA0003);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_count", {16'd0, xfer_count}, 32'd4);

      // Streaming
      for (int i = 0; i < 100; i++) step(1'b1, 32'h5000_0000 + 32'(i), 1'b1, 1'b0);
      chk("stream_occ", {30'd0, occupancy}, 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("stream_count", {16'd0, xfer_count}, 32'd104);

      // Flush collision from a full buffer
      step(1'b1, 32'hBBBB0001, 1'b0, 1'b0);
      step(1'b1, 32'hBBBB0002, 1'b0, 1'b0);
      step(1'b1, 32'hDEAD0000, 1'b1, 1'b1);
      chk("flush_state", {29'd0, out_valid, in_ready, 1'b0}, {29'd0, 1'b0, 1'b1, 1'b0});
      chk("flush_count", {16'd0, xfer_count}, 32'd105);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("dead_never_out", {31'd0, dead_seen}, 32'd0);

      // Random traffic
      for (int i = 0; i < 600; i++)
         step(1'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 15) == 0));

      // Reset mid-cycle while full
      step(1'b1, 32'hCCCC0001, 1'b0, 1'b0);
      step(1'b1, 32'hCCCC0002, 1'b0, 1'b0);
      #3 RSTn = 1'b0;
      #1;
      mq.delete();
      shown = '0;
      mcnt  = '0;
      check_model();
      #2 RSTn = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0);

      // Counter wrap
      while (mcnt != 16'hFFFF) step(1'b1, 32'(mcnt), 1'b1, 1'b0);
      chk("pre_wrap", {16'd0, xfer_count}, 32'h0000FFFF);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("wrap", {16'd0, xfer_count}, 32'h00000000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
